pe_control_v3: RTL and testbench

//  Parametrised successor of the PE control FSM for the output-stationary systolic array.

---
 rtl/pe_control_v3.sv | 130 +++++++++++++
 tb/tb_pe_control_v3.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_control_v3.sv
// PE control FSM for the output-stationary systolic array: NORMAL/DRAIN sequencing with
// multi-accumulator drain, wavefront restart and valid-hold. Optional macro: PE_CTRL_FAULT_EN.
module pe_control_v3 #(
    parameter int D_W           = 8,
    parameter int DRAIN_LEN     = 1,
    parameter int HOLD_ON_VALID = 1,
    localparam int CNT_W        = (DRAIN_LEN > 2) ? $clog2(DRAIN_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             in_valid,
    input  logic             out_stagevalid_from_dp,
`ifdef PE_CTRL_FAULT_EN
    input  logic             fault_en,
    input  logic [1:0]       fault_type,
`endif
    output logic             init_r,
    output logic             in_valid_r,
    output logic             data_rsrv,
    output logic             out_valid,
    output logic [CNT_W-1:0] drain_idx,
    output logic             drain_done
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               HOLD_EN  = (HOLD_ON_VALID != 0);

    if (DRAIN_LEN < 1) begin : g_bad_drain_len
        $error("pe_control_v3: DRAIN_LEN must be >= 1");
    end
    if (D_W < 1) begin : g_bad_d_w
        $error("pe_control_v3: D_W must be >= 1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               init_r_q, in_valid_r_q;
    logic               out_valid_q, out_valid_d;
    logic               drain_done_q, drain_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            cnt_q        <= '0;
            init_r_q     <= 1'b0;
            in_valid_r_q <= 1'b0;
            out_valid_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_r_q     <= init;
            in_valid_r_q <= in_valid;
            out_valid_q  <= out_valid_d;
            drain_done_q <= drain_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        drain_done_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (init_r_q) begin
                    state_d     = ST_DRAIN;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = in_valid_r_q;
                end
            end
            ST_DRAIN: begin
                out_valid_d = out_stagevalid_from_dp;
                // A new wavefront always wins over finishing the current drain.
                if (init_r_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    if (!HOLD_EN || !in_valid_r_q) begin
                        state_d      = ST_NORMAL;
                        cnt_d        = '0;
                        drain_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    // The state flop is the registered (next_state == DRAIN) decision.
    assign data_rsrv  = (state_q == ST_DRAIN);
    assign init_r     = init_r_q;
    assign in_valid_r = in_valid_r_q;
    assign drain_idx  = cnt_q;
    assign drain_done = drain_done_q;

`ifdef PE_CTRL_FAULT_EN
    logic out_valid_fault;

    always_comb begin
        out_valid_fault = out_valid_q;
        if (fault_en) begin
            case (fault_type)
                2'b00:   out_valid_fault = 1'b0;
                2'b01:   out_valid_fault = 1'b1;
                2'b10:   out_valid_fault = ~out_valid_q;
                default: out_valid_fault = out_valid_q;
            endcase
        end
    end

    assign out_valid = out_valid_fault;
`else
    assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_pe_control_v3.sv
// Self-checking bench for pe_control_v3: three instances (DRAIN_LEN 4/hold, 2/hold, 2/no-hold)
// share stimulus; table rows are {rst,init,in_valid,stagevalid, init_r,in_valid_r,data_rsrv,out_valid,drain_done,idx[1:0]}.
module tb_pe_control_v3;

    logic clk = 1'b0;
    logic rst, init, in_valid, stage;
`ifdef PE_CTRL_FAULT_EN
    logic       fault_en   = 1'b0;
    logic [1:0] fault_type = 2'b11;
`endif

    logic       ir_a, ivr_a, rsrv_a, ov_a, done_a;
    logic [1:0] idx_a;
    logic       ir_b, ivr_b, rsrv_b, ov_b, done_b;
    logic [0:0] idx_b;
    logic       ir_c, ivr_c, rsrv_c, ov_c, done_c;
    logic [0:0] idx_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pe_control_v3 #(.D_W(8), .DRAIN_LEN(4), .HOLD_ON_VALID(1)) u_dut_a (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
        .out_stagevalid_from_dp(stage),
`ifdef PE_CTRL_FAULT_EN
        .fault_en(fault_en), .fault_type(fault_type),
`endif
        .init_r(ir_a), .in_valid_r(ivr_a), .data_rsrv(rsrv_a), .out_valid(ov_a),
        .drain_idx(idx_a), .drain_done(done_a)
    );

    pe_control_v3 #(.D_W(8), .DRAIN_LEN(2), .HOLD_ON_VALID(1)) u_dut_b (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
        .out_stagevalid_from_dp(stage),
`ifdef PE_CTRL_FAULT_EN
        .fault_en(fault_en), .fault_type(fault_type),
`endif
        .init_r(ir_b), .in_valid_r(ivr_b), .data_rsrv(rsrv_b), .out_valid(ov_b),
        .drain_idx(idx_b), .drain_done(done_b)
    );

    pe_control_v3 #(.D_W(8), .DRAIN_LEN(2), .HOLD_ON_VALID(0)) u_dut_c (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
        .out_stagevalid_from_dp(stage),
`ifdef PE_CTRL_FAULT_EN
        .fault_en(fault_en), .fault_type(fault_type),
`endif
        .init_r(ir_c), .in_valid_r(ivr_c), .data_rsrv(rsrv_c), .out_valid(ov_c),
        .drain_idx(idx_c), .drain_done(done_c)
    );

    // drain_idx is only meaningful while draining, so it is masked when DRAIN is not expected.
    function automatic logic [6:0] sample(input int which, input logic want_rsrv);
        logic [6:0] v;
        case (which)
            0:       v = {ir_a, ivr_a, rsrv_a, ov_a, done_a, idx_a};
            1:       v = {ir_b, ivr_b, rsrv_b, ov_b, done_b, 1'b0, idx_b};
            default: v = {ir_c, ivr_c, rsrv_c, ov_c, done_c, 1'b0, idx_c};
        endcase
        if (!want_rsrv) v[1:0] = 2'b00;
        return v;
    endfunction

    task automatic apply_row(input logic [10:0] r, input logic [6:0] expv);
        rst      = r[10];
        init     = r[9];
        in_valid = r[8];
        stage    = r[7];
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; init = 1'b0; in_valid = 1'b0; stage = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] tbl [5];
        logic [6:0]  e, a;
        tbl = '{11'b1110_00000_00, 11'b1110_00000_00, 11'b1110_00000_00,
                11'b0000_00000_00, 11'b0110_11000_00};
        for (int i = 0; i < 5; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            for (int w = 0; w < 3; w++) begin
                a = sample(w, e[4]);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL reset row %0d dut %0d: got %b required %b", i, w, a, e);
                end
            end
            $display("reset row %0d: exp %b", i, e);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [10:0] tbl [6];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0000_00110_00, 11'b0000_00100_01,
                11'b1000_00000_00, 11'b0000_00000_00, 11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(0, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset_mid_drain row %0d: got %b required %b", i, a, e);
            end else $display("reset_mid_drain row %0d: %b", i, a);
        end
    endtask

    task automatic test_drain();
        logic [10:0] tbl [7];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0000_00110_00, 11'b0001_00110_01,
                11'b0000_00100_10, 11'b0001_00110_11, 11'b0000_00001_00,
                11'b0001_00000_00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(0, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL drain row %0d: got %b required %b", i, a, e);
            end else $display("drain row %0d: %b", i, a);
        end
    endtask

    task automatic test_restart();
        logic [10:0] tbl [10];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0000_00110_00, 11'b0000_00100_01,
                11'b0100_10100_10, 11'b0000_00100_00, 11'b0001_00110_01,
                11'b0000_00100_10, 11'b0000_00100_11, 11'b0000_00001_00,
                11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(0, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL restart row %0d: got %b required %b", i, a, e);
            end else $display("restart row %0d: %b", i, a);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] tbl [11];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0000_00110_00, 11'b0001_00110_01,
                11'b0000_00100_10, 11'b0100_10100_11, 11'b0000_00100_00,
                11'b0000_00100_01, 11'b0000_00100_10, 11'b0001_00110_11,
                11'b0000_00001_00, 11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(0, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL back_to_back row %0d: got %b required %b", i, a, e);
            end else $display("back_to_back row %0d: %b", i, a);
        end
    endtask

    task automatic test_hold();
        logic [10:0] tbl [9];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0010_01110_00, 11'b0010_01100_01,
                11'b0010_01100_01, 11'b0011_01110_01, 11'b0010_01100_01,
                11'b0000_00100_01, 11'b0000_00001_00, 11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(1, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL hold row %0d: got %b required %b", i, a, e);
            end else $display("hold row %0d: %b", i, a);
        end
    endtask

    task automatic test_no_hold();
        logic [10:0] tbl [9];
        logic [6:0]  e, a;
        tbl = '{11'b0100_10000_00, 11'b0010_01110_00, 11'b0010_01100_01,
                11'b0010_01001_00, 11'b0011_01010_00, 11'b0010_01010_00,
                11'b0000_00010_00, 11'b0000_00000_00, 11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(2, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL no_hold row %0d: got %b required %b", i, a, e);
            end else $display("no_hold row %0d: %b", i, a);
        end
    endtask

    task automatic test_normal();
        logic [10:0] tbl [5];
        logic [6:0]  e, a;
        tbl = '{11'b0010_01000_00, 11'b0001_00010_00, 11'b0010_01000_00,
                11'b0001_00010_00, 11'b0000_00000_00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_row(tbl[i], tbl[i][6:0]);
            e = exp_q.pop_front();
            a = sample(0, e[4]);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL normal row %0d: got %b required %b", i, a, e);
            end else $display("normal row %0d: %b", i, a);
        end
    endtask

`ifdef PE_CTRL_FAULT_EN
    task automatic test_fault();
        logic [10:0] tbl [7];
        logic [6:0]  e, a, ev;
        tbl = '{11'b0100_10000_00, 11'b0000_00110_00, 11'b0001_00110_01,
                11'b0000_00100_10, 11'b0001_00110_11, 11'b0000_00001_00,
                11'b0001_00000_00};
        for (int ft = 0; ft < 4; ft++) begin
            fault_en   = 1'b0;
            do_reset();
            fault_en   = 1'b1;
            fault_type = 2'(ft);
            for (int i = 0; i < 7; i++) begin
                ev = tbl[i][6:0];
                case (ft)
                    0:       ev[3] = 1'b0;
                    1:       ev[3] = 1'b1;
                    2:       ev[3] = ~ev[3];
                    default: ev[3] = ev[3];
                endcase
                apply_row(tbl[i], ev);
                e = exp_q.pop_front();
                a = sample(0, e[4]);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL fault type %0d row %0d: got %b required %b", ft, i, a, e);
                end else $display("fault type %0d row %0d: %b", ft, i, a);
            end
        end
        fault_en = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; init = 1'b1; in_valid = 1'b1; stage = 1'b0;
        test_reset();
        test_reset_mid_drain();
        test_drain();
        test_restart();
        test_back_to_back();
        test_hold();
        test_no_hold();
        test_normal();
`ifdef PE_CTRL_FAULT_EN
        test_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
